// File: rtl/perf_session_ctrl_if.sv
// Purpose: bundles the session controller's control, counter-select and readout signals.
// Latency: none, wiring only.
// Backpressure: out_valid/out_ready handshake on the readout word; the monitor side has no flow control.
interface perf_session_ctrl_if;
  logic        start;
  logic        stop;
  logic        halt_detect;
  logic        perf_enable;
  logic        cnt_clear;
  logic [3:0]  cnt_sel;
  logic [31:0] cnt_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  // Controller side: drives the monitor controls and the readout word.
  modport master (
    input  start, stop, halt_detect, cnt_data, out_ready,
    output perf_enable, cnt_clear, cnt_sel, out_valid, out_index, out_data, out_last, busy, done
  );

  // Environment side: software requests, core status, monitor data and the readout sink.
  modport slave (
    output start, stop, halt_detect, cnt_data, out_ready,
    input  perf_enable, cnt_clear, cnt_sel, out_valid, out_index, out_data, out_last, busy, done
  );
endinterface

// File: rtl/perf_session_ctrl.sv
// Purpose: runs one measurement session: clear counters, count until stop or sustained halt, read every counter out.
// Latency: start -> counting after 2 cycles; stop/halt end -> first word valid after 3 cycles; 2 cycles per word.
// Backpressure: a readout word is held stable in SEND until out_ready; the FSM waits there indefinitely.
module perf_session_ctrl #(
  parameter int NUM_CNT     = 9,
  parameter int HALT_CYCLES = 10
) (
  input logic                 clk,
  input logic                 rst,
  perf_session_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    FREEZE = 3'd3,
    LOAD   = 3'd4,
    SEND   = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [3:0] LAST_IDX  = 4'(NUM_CNT - 1);
  localparam logic [7:0] HALT_LAST = 8'(HALT_CYCLES - 1);

  state_t      state;
  logic [3:0]  index;
  logic [7:0]  halt_cnt;
  logic        perf_enable_q;
  logic        cnt_clear_q;
  logic        out_valid_q;
  logic [3:0]  out_index_q;
  logic [31:0] out_data_q;
  logic        out_last_q;
  logic        busy_q;
  logic        done_q;

  // The current cycle is the last of the required run of consecutive halt cycles.
  logic halt_end;
  assign halt_end = bus.halt_detect && (halt_cnt == HALT_LAST);

  assign bus.perf_enable = perf_enable_q;
  assign bus.cnt_clear   = cnt_clear_q;
  assign bus.cnt_sel     = index;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_index   = out_index_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

  // Session FSM; every output is registered and set on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      index         <= 4'd0;
      halt_cnt      <= 8'd0;
      perf_enable_q <= 1'b0;
      cnt_clear_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_index_q   <= 4'd0;
      out_data_q    <= 32'd0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      cnt_clear_q <= 1'b0;
      done_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= CLEAR;
            cnt_clear_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        CLEAR: begin
          // A fresh session always starts its halt run from zero.
          state         <= RUN;
          halt_cnt      <= 8'd0;
          perf_enable_q <= 1'b1;
        end
        RUN: begin
          if (!bus.halt_detect) begin
            halt_cnt <= 8'd0;
          end else if (halt_cnt != 8'hFF) begin
            halt_cnt <= halt_cnt + 8'd1;
          end
          if (bus.stop || halt_end) begin
            state         <= FREEZE;
            perf_enable_q <= 1'b0;
            index         <= 4'd0;
          end
        end
        FREEZE: begin
          // One settle cycle so the monitor's last increment lands before readout.
          state <= LOAD;
        end
        LOAD: begin
          state       <= SEND;
          out_data_q  <= bus.cnt_data;
          out_index_q <= index;
          out_last_q  <= (index == LAST_IDX);
          out_valid_q <= 1'b1;
        end
        SEND: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (index == LAST_IDX) begin
              state  <= DONE;
              index  <= 4'd0;
              done_q <= 1'b1;
            end else begin
              state <= LOAD;
              index <= index + 4'd1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
